// File: rtl/spi_master_ctrl_if.sv
// Host-side command / read-return bus of spi_master_ctrl.
// The host drives through the master modport; the controller uses the slave modport.
interface spi_master_ctrl_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] cmd_data;
    logic                 rd_valid;
    logic [ADDR_SIZE-1:0] rd_data;
    logic                 busy;
    logic                 seq_err;

    modport master (
        output cmd_valid, cmd, cmd_data,
        input  cmd_ready, rd_valid, rd_data, busy, seq_err
    );

    modport slave (
        input  cmd_valid, cmd, cmd_data,
        output cmd_ready, rd_valid, rd_data, busy, seq_err
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises {cmd, payload} frames to the SPI-slave RAM wrapper and captures read bytes on MISO.
// Optional build macro SPI_MASTER_SEQCHK_EN rejects a read-data command when no read address is pending.
module spi_master_ctrl #(
    parameter int ADDR_SIZE  = 8,
    parameter int TURNAROUND = 2,
    parameter int GAP        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_ctrl_if.slave host,
    output logic             SS_n,
    output logic             MOSI,
    input  logic             MISO
);
    localparam int FW = ADDR_SIZE + 2;
    localparam int CW = $clog2(FW + TURNAROUND + GAP + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TURN  = 3'd3,
        ST_CAPT  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t               state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [FW-1:0]        frame_r;
    logic [1:0]           cmd_r;
    logic [ADDR_SIZE-2:0] cap_r;
    logic [ADDR_SIZE-1:0] rd_data_r;
    logic                 rd_valid_r, rd_valid_s;
    logic                 ss_n_r, ss_n_s;
    logic                 mosi_r, mosi_s;
    logic                 cmd_ready_r, busy_r, seq_err_r, rd_pend_r;
    logic                 accept_s, reject_s, load_s;
    logic                 shift_s, capt_s, set_pend_s, clr_pend_s;

    // cmd_ready_r is only ever high while sitting in IDLE, so this is the accept edge.
    assign accept_s = host.cmd_valid && cmd_ready_r;

`ifdef SPI_MASTER_SEQCHK_EN
    assign reject_s = accept_s && (host.cmd == 2'b11) && !rd_pend_r;
`else
    // The pending flag is still tracked here; only the checked build acts on it.
    assign reject_s = 1'b0 & rd_pend_r;
`endif

    assign load_s = accept_s && !reject_s;

    // Next-state, bit/cycle counter and serial-output decode.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        mosi_s     = 1'b0;
        rd_valid_s = 1'b0;
        shift_s    = 1'b0;
        capt_s     = 1'b0;
        set_pend_s = 1'b0;
        clr_pend_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (reject_s) begin
                    state_s = ST_GAP;
                    cnt_s   = '0;
                end else if (accept_s) begin
                    state_s = ST_SEL;
                    mosi_s  = host.cmd[1];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEL: begin
                state_s = ST_SHIFT;
                cnt_s   = CW'(FW - 1);
                mosi_s  = frame_r[FW-1];
            end
            ST_SHIFT: begin
                // frame_r shifts left each bit, so the next bit always sits just below the MSB.
                if (cnt_r != '0) begin
                    cnt_s   = cnt_r - CW'(1);
                    mosi_s  = frame_r[FW-2];
                    shift_s = 1'b1;
                end else if (cmd_r != 2'b11) begin
                    state_s    = ST_GAP;
                    cnt_s      = CW'(GAP - 1);
                    set_pend_s = (cmd_r == 2'b10);
                end else if (TURNAROUND == 0) begin
                    state_s = ST_CAPT;
                    cnt_s   = CW'(ADDR_SIZE - 1);
                end else begin
                    state_s = ST_TURN;
                    cnt_s   = CW'(TURNAROUND - 1);
                end
            end
            ST_TURN: begin
                if (cnt_r != '0) begin
                    cnt_s = cnt_r - CW'(1);
                end else begin
                    state_s = ST_CAPT;
                    cnt_s   = CW'(ADDR_SIZE - 1);
                end
            end
            ST_CAPT: begin
                capt_s = 1'b1;
                if (cnt_r != '0) begin
                    cnt_s = cnt_r - CW'(1);
                end else begin
                    state_s    = ST_GAP;
                    cnt_s      = CW'(GAP - 1);
                    rd_valid_s = 1'b1;
                    clr_pend_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_r != '0) begin
                    cnt_s = cnt_r - CW'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        ss_n_s = !(state_s inside {ST_SEL, ST_SHIFT, ST_TURN, ST_CAPT});
    end

    // State, counter and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            ss_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            rd_valid_r  <= 1'b0;
            seq_err_r   <= 1'b0;
            rd_pend_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ss_n_r      <= ss_n_s;
            mosi_r      <= mosi_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            rd_valid_r  <= rd_valid_s;
            seq_err_r   <= reject_s;
            if (set_pend_s) begin
                rd_pend_r <= 1'b1;
            end else if (clr_pend_s) begin
                rd_pend_r <= 1'b0;
            end
        end
    end

    // Frame shift register, MISO capture shifter and read-data holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r   <= '0;
            cmd_r     <= 2'b00;
            cap_r     <= '0;
            rd_data_r <= '0;
        end else begin
            if (load_s) begin
                frame_r <= {host.cmd, host.cmd_data};
                cmd_r   <= host.cmd;
            end else if (shift_s) begin
                frame_r <= {frame_r[FW-2:0], 1'b0};
            end
            if (capt_s) begin
                cap_r <= {cap_r[ADDR_SIZE-3:0], MISO};
            end
            if (rd_valid_s) begin
                rd_data_r <= {cap_r, MISO};
            end
        end
    end

    assign SS_n           = ss_n_r;
    assign MOSI           = mosi_r;
    assign host.cmd_ready = cmd_ready_r;
    assign host.busy      = busy_r;
    assign host.rd_valid  = rd_valid_r;
    assign host.rd_data   = rd_data_r;
    assign host.seq_err   = seq_err_r;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: wrapper golden model on the SPI pins plus a
// command-level reference (memory / address / pending flag) predicting every frame trace.
module tb_spi_master_ctrl;
    localparam int A  = 8;
    localparam int TA = 2;
    localparam int FW = A + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic MISO  = 1'b0;
    logic SS_n, MOSI;
    int   n_tests = 0;
    int   n_fail  = 0;

    spi_master_ctrl_if #(.ADDR_SIZE(A)) bus ();

    spi_master_ctrl #(.ADDR_SIZE(A), .TURNAROUND(TA), .GAP(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .host (bus),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    always #5 clk = ~clk;

    // Command-level reference of what the wrapper should hold.
    logic [A-1:0] ref_mem [256] = '{default: '0};
    logic [A-1:0] ref_waddr = '0;
    logic [A-1:0] ref_raddr = '0;
    logic [A-1:0] ref_rd    = '0;
    bit           ref_pend  = 1'b0;

    // Wrapper golden model: decodes MOSI frames, answers read-data frames on MISO.
    logic [A-1:0]  s_mem [256] = '{default: '0};
    logic [A-1:0]  s_waddr = '0;
    logic [A-1:0]  s_raddr = '0;
    logic [A-1:0]  s_byte  = '0;
    logic [FW-1:0] s_frame = '0;
    int            s_idx   = 0;

    always @(negedge clk) begin
        if (SS_n !== 1'b0) begin
            s_idx = 0;
            MISO  = 1'b0;
        end else begin
            if (s_idx >= 1 && s_idx <= FW) s_frame = {s_frame[FW-2:0], MOSI};
            if (s_idx == FW) begin
                case (s_frame[FW-1:FW-2])
                    2'b00:   s_waddr = s_frame[A-1:0];
                    2'b01:   s_mem[s_waddr] = s_frame[A-1:0];
                    2'b10:   s_raddr = s_frame[A-1:0];
                    default: s_byte = s_mem[s_raddr];
                endcase
            end
            if (s_idx >= FW + 1 + TA && s_idx < FW + 1 + TA + A)
                MISO = s_byte[A - 1 - (s_idx - (FW + 1 + TA))];
            else
                MISO = 1'b0;
            s_idx = s_idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command, wait for accept, record the cycle trace and compare with the prediction.
    task automatic do_cmd(input logic [1:0] c, input logic [A-1:0] d, input bit hold);
        int            waited, len, w;
        bit            rej, is_rd;
        logic [FW-1:0] fr;
        logic [A-1:0]  e_rd;
        logic [31:0]   o_ssn, o_mosi, o_rdv, o_seq, o_rdy, o_busy;
        logic [31:0]   e_ssn, e_mosi, e_rdv, e_seq, e_rdy, e_busy;
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.cmd_data  = d;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", 32'(waited < 40), 32'd1);
        if (waited >= 40) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        rej = 1'b0;
`ifdef SPI_MASTER_SEQCHK_EN
        rej = (c == 2'b11) && !ref_pend;
`endif
        is_rd = (c == 2'b11) && !rej;
        len   = rej ? 0 : (is_rd ? 1 + FW + TA + A : 1 + FW);
        w     = len + 2;
        fr    = {c, d};
        {e_ssn, e_mosi, e_rdv, e_seq, e_rdy, e_busy} = '0;
        {o_ssn, o_mosi, o_rdv, o_seq, o_rdy, o_busy} = '0;
        for (int i = 0; i < w; i++) begin
            e_ssn[i]  = (i >= len);
            e_rdy[i]  = (i == len + 1);
            e_busy[i] = (i <= len);
            if (len > 0 && i == 0) e_mosi[i] = c[1];
            else if (len > 0 && i >= 1 && i <= FW) e_mosi[i] = fr[FW - i];
        end
        if (is_rd) e_rdv[len] = 1'b1;
        if (rej) e_seq[0] = 1'b1;
        if (!rej) begin
            case (c)
                2'b00:   ref_waddr = d;
                2'b01:   ref_mem[ref_waddr] = d;
                2'b10:   begin ref_raddr = d; ref_pend = 1'b1; end
                default: begin ref_rd = ref_mem[ref_raddr]; ref_pend = 1'b0; end
            endcase
        end
        e_rd = ref_rd;
        @(posedge clk);
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            o_ssn[i]  = SS_n;
            o_mosi[i] = MOSI;
            o_rdv[i]  = bus.rd_valid;
            o_seq[i]  = bus.seq_err;
            o_rdy[i]  = bus.cmd_ready;
            o_busy[i] = bus.busy;
            if (!hold && i == 0) begin
                bus.cmd_valid = 1'($urandom & 1);
                bus.cmd       = 2'($urandom);
                bus.cmd_data  = A'($urandom);
            end
            if (!hold && i == len) bus.cmd_valid = 1'b0;
        end
        chk("ss_n_trace", o_ssn, e_ssn);
        chk("mosi_trace", o_mosi, e_mosi);
        chk("rd_valid_trace", o_rdv, e_rdv);
        chk("seq_err_trace", o_seq, e_seq);
        chk("cmd_ready_trace", o_rdy, e_rdy);
        chk("busy_trace", o_busy, e_busy);
        chk("rd_data", 32'(bus.rd_data), 32'(e_rd));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_rdv, any_ssl;
        int   waited;
        logic [1:0] rc;
        logic [A-1:0] rd;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.cmd_data  = '0;

        repeat (3) @(negedge clk);
        chk("rst_ss_n", 32'(SS_n), 32'd1);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_seq_err", 32'(bus.seq_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

        // Read-data straight after reset: rejected or issued depending on build.
        do_cmd(2'b11, 8'h00, 1'b0);
        do_cmd(2'b00, 8'hA5, 1'b0);

        // Write then read back through the wrapper model.
        do_cmd(2'b00, 8'h3C, 1'b0);
        do_cmd(2'b01, 8'h5A, 1'b0);
        do_cmd(2'b10, 8'h3C, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b0);
        chk("golden_read", 32'(bus.rd_data), 32'h5A);

        // cmd_valid held high across two different back-to-back commands.
        do_cmd(2'b00, 8'h11, 1'b1);
        do_cmd(2'b01, 8'h77, 1'b1);
        bus.cmd_valid = 1'b0;
        do_cmd(2'b10, 8'h11, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b0);
        chk("hold_read", 32'(bus.rd_data), 32'h77);

        for (int k = 0; k < 40; k++) begin
            rc = 2'($urandom_range(0, 3));
            rd = (rc == 2'b00 || rc == 2'b10) ? A'($urandom_range(0, 7)) : A'($urandom);
            do_cmd(rc, rd, ($urandom_range(0, 3) == 0));
        end
        bus.cmd_valid = 1'b0;

        // Reset asserted in the middle of a read-data frame.
        do_cmd(2'b10, 8'h3C, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd       = 2'b11;
        bus.cmd_data  = 8'h00;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_accept_wait", 32'(waited < 40), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ss_n", 32'(SS_n), 32'd1);
        chk("abort_mosi", 32'(MOSI), 32'd0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        any_rdv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any_rdv = any_rdv | bus.rd_valid;
        end
        chk("abort_no_rdv_in_rst", 32'(any_rdv), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_rd_data", 32'(bus.rd_data), 32'd0);
        ref_pend = 1'b0;
        ref_rd   = '0;
        any_rdv  = 1'b0;
        any_ssl  = 1'b0;
        repeat (25) begin
            @(negedge clk);
            any_rdv = any_rdv | bus.rd_valid;
            any_ssl = any_ssl | !SS_n;
        end
        chk("abort_no_rdv_after", 32'(any_rdv), 32'd0);
        chk("abort_ss_n_idle", 32'(any_ssl), 32'd0);

        do_cmd(2'b11, 8'h00, 1'b0);
        do_cmd(2'b10, 8'h3C, 1'b0);
        do_cmd(2'b11, 8'h00, 1'b0);
        chk("recover_read", 32'(bus.rd_data), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
